// File: rtl/hazard_control_unit_pkg.sv
// rtl/hazard_control_unit_pkg.sv - shared types for the hazard control unit
package hazard_control_unit_pkg;
    localparam int REG_BITS = 5;

    typedef logic [REG_BITS-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hcu_state_t;
endpackage

// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - pipeline-side hazard inputs and stall/flush controls
interface hazard_control_unit_if
    import hazard_control_unit_pkg::*;
#(
    parameter int REG_W = $bits(regbits_t),
    parameter int CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic [REG_W-1:0] fd_rsel1;
    logic [REG_W-1:0] fd_rsel2;
    logic             fd_uses_rs1;
    logic             fd_uses_rs2;
    logic             de_Mem_Read;
    logic [REG_W-1:0] de_wsel;
    logic             ex_redirect;
    logic             em_mem_req;
    logic             ex_halt;
    logic             pc_en;
    logic             fd_stall;
    logic             fd_flush;
    logic             de_stall;
    logic             de_flush;
    logic             em_stall;
    logic             halted;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    // The pipeline (master) reports hazards; the control unit (slave) answers with controls.
    modport master (
        output ihit, dhit, fd_rsel1, fd_rsel2, fd_uses_rs1, fd_uses_rs2,
               de_Mem_Read, de_wsel, ex_redirect, em_mem_req, ex_halt,
        input  pc_en, fd_stall, fd_flush, de_stall, de_flush, em_stall, halted,
               stall_count, flush_count
    );

    modport slave (
        input  ihit, dhit, fd_rsel1, fd_rsel2, fd_uses_rs1, fd_uses_rs2,
               de_Mem_Read, de_wsel, ex_redirect, em_mem_req, ex_halt,
        output pc_en, fd_stall, fd_flush, de_stall, de_flush, em_stall, halted,
               stall_count, flush_count
    );
endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// rtl/hazard_control_unit_sat_counter.sv - saturating event counter with enable
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] count_o
);
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q;

    // Holds at all-ones so a long run never wraps back to a small count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + ONE;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use, redirect, dmem-wait and halt stall/flush control
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic                 CLK,
    input  logic                 nRST,
    hazard_control_unit_if.slave bus
);
    hcu_state_t       state_q;
    logic             flush_pend_q;
    logic [REG_W-1:0] wsel;
    logic             lu;
    logic             fl;
    logic             any_stall;
    logic             flush_commit;

    assign wsel = bus.de_wsel;
    assign lu   = bus.de_Mem_Read && (wsel != '0) &&
                  ((bus.fd_uses_rs1 && (bus.fd_rsel1 == wsel)) ||
                   (bus.fd_uses_rs2 && (bus.fd_rsel2 == wsel)));
    assign fl   = bus.ex_redirect || flush_pend_q;

    // A redirect seen while fetch misses is remembered until the registers advance.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= RUN;
            flush_pend_q <= 1'b0;
        end else begin
            if (bus.ihit) begin
                flush_pend_q <= 1'b0;
            end else if (bus.ex_redirect) begin
                flush_pend_q <= 1'b1;
            end
            case (state_q)
                RUN: begin
                    if (bus.em_mem_req && !bus.dhit) begin
                        state_q <= MEM_WAIT;
                    end else if (bus.ex_halt && bus.ihit) begin
                        state_q <= HALT;
                    end
                end
                MEM_WAIT: begin
                    if (bus.dhit) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= HALT;
            endcase
        end
    end

    always_comb begin
        bus.pc_en    = 1'b0;
        bus.fd_stall = 1'b0;
        bus.fd_flush = 1'b0;
        bus.de_stall = 1'b0;
        bus.de_flush = 1'b0;
        bus.em_stall = 1'b0;
        bus.halted   = 1'b0;
        if (nRST) begin
            case (state_q)
                RUN: begin
                    if (fl) begin
                        bus.fd_flush = 1'b1;
                        bus.de_flush = 1'b1;
                        bus.pc_en    = 1'b1;
                    end else if (lu) begin
                        bus.fd_stall = 1'b1;
                        bus.de_stall = 1'b1;
                    end else begin
                        bus.pc_en    = bus.ihit;
                    end
                end
                MEM_WAIT: begin
                    bus.fd_stall = 1'b1;
                    bus.em_stall = 1'b1;
                end
                default: begin
                    bus.fd_stall = 1'b1;
                    bus.de_flush = 1'b1;
                    bus.halted   = 1'b1;
                end
            endcase
        end
    end

    assign any_stall    = bus.fd_stall || bus.de_stall || bus.em_stall;
    assign flush_commit = bus.fd_flush && bus.ihit;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (CLK),
        .rst_n   (nRST),
        .en_i    (any_stall),
        .count_o (bus.stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (CLK),
        .rst_n   (nRST),
        .en_i    (flush_commit),
        .count_o (bus.flush_count)
    );
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - scoreboard bench for hazard_control_unit
module tb_hazard_control_unit;
    localparam int CW = 4;

    // {pc_en, fd_stall, fd_flush, de_stall, de_flush, em_stall, halted}
    localparam logic [6:0] O_OFF  = 7'b0000000;
    localparam logic [6:0] O_RUN  = 7'b1000000;
    localparam logic [6:0] O_LU   = 7'b0101000;
    localparam logic [6:0] O_FL   = 7'b1010100;
    localparam logic [6:0] O_MW   = 7'b0100010;
    localparam logic [6:0] O_HALT = 7'b0100101;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   n_err = 0;
    int   n_chk = 0;
    logic [CW-1:0] exp_stall = '0;
    logic [CW-1:0] exp_flush = '0;
    logic [6:0]    exp_q[$];
    logic [6:0]    obs;

    always #5 CLK = ~CLK;

    hazard_control_unit_if #(.REG_W(5), .CNT_W(CW)) bus ();

    hazard_control_unit #(.CNT_W(CW), .REG_W(5)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    assign obs = {bus.pc_en, bus.fd_stall, bus.fd_flush, bus.de_stall,
                  bus.de_flush, bus.em_stall, bus.halted};

    task automatic clear_inputs();
        bus.ihit = 1'b0; bus.dhit = 1'b0;
        bus.fd_rsel1 = '0; bus.fd_rsel2 = '0;
        bus.fd_uses_rs1 = 1'b0; bus.fd_uses_rs2 = 1'b0;
        bus.de_Mem_Read = 1'b0; bus.de_wsel = '0;
        bus.ex_redirect = 1'b0; bus.em_mem_req = 1'b0; bus.ex_halt = 1'b0;
    endtask

    function automatic void model_update(input logic [6:0] e, input logic ih);
        if ((e[5] || e[3] || e[1]) && (exp_stall != {CW{1'b1}})) exp_stall = exp_stall + 1'b1;
        if (e[4] && ih && (exp_flush != {CW{1'b1}})) exp_flush = exp_flush + 1'b1;
    endfunction

    task automatic test_reset();
        logic [6:0] e;
        clear_inputs();
        bus.ihit = 1'b1;
        exp_q.push_back(O_OFF);
        #12;
        e = exp_q.pop_front();
        n_chk++;
        if (obs !== e) begin n_err++; $display("FAIL reset_outputs got=%b exp=%b", obs, e); end
        n_chk++;
        if (bus.stall_count !== '0 || bus.flush_count !== '0) begin
            n_err++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.stall_count, bus.flush_count);
        end
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_hazard_cases();
        logic [6:0] e;
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            bus.ihit = 1'b1;
            bus.de_Mem_Read = (c != 3);
            case (c)
                0: begin bus.de_wsel = 5'd0; bus.fd_rsel1 = 5'd0; bus.fd_uses_rs1 = 1'b1; end
                1: begin bus.de_wsel = 5'd5; bus.fd_rsel1 = 5'd5; bus.fd_uses_rs1 = 1'b0; end
                default: begin bus.de_wsel = 5'd5; bus.fd_rsel2 = 5'd5; bus.fd_uses_rs2 = 1'b1; end
            endcase
            exp_q.push_back(c == 2 ? O_LU : O_RUN);
            @(negedge CLK);
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL hazard_case%0d got=%b exp=%b", c, obs, e); end
            model_update(e, bus.ihit);
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_load_use();
        logic [6:0] e;
        for (int c = 0; c < 2; c++) begin
            clear_inputs();
            bus.ihit = 1'b1;
            bus.fd_uses_rs1 = 1'b1; bus.fd_rsel1 = 5'd5; bus.de_wsel = 5'd5;
            bus.de_Mem_Read = (c == 0);
            exp_q.push_back(c == 0 ? O_LU : O_RUN);
            @(negedge CLK);
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL load_use_c%0d got=%b exp=%b", c, obs, e); end
            model_update(e, bus.ihit);
            @(posedge CLK); #1;
        end
        n_chk++;
        if (bus.stall_count !== exp_stall) begin
            n_err++; $display("FAIL load_use_stall_count got=%0d exp=%0d", bus.stall_count, exp_stall);
        end
    endtask

    task automatic test_redirect_miss();
        logic [6:0] e;
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            bus.ex_redirect = (c < 3);
            bus.ihit = (c >= 3);
            exp_q.push_back(c < 4 ? O_FL : O_RUN);
            @(negedge CLK);
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL redirect_miss_c%0d got=%b exp=%b", c, obs, e); end
            model_update(e, bus.ihit);
            @(posedge CLK); #1;
        end
        n_chk++;
        if (bus.flush_count !== exp_flush) begin
            n_err++; $display("FAIL redirect_flush_count got=%0d exp=%0d", bus.flush_count, exp_flush);
        end
    endtask

    task automatic test_flush_over_lu();
        logic [6:0] e;
        clear_inputs();
        bus.ihit = 1'b1; bus.ex_redirect = 1'b1;
        bus.de_Mem_Read = 1'b1; bus.de_wsel = 5'd7;
        bus.fd_uses_rs2 = 1'b1; bus.fd_rsel2 = 5'd7;
        exp_q.push_back(O_FL);
        @(negedge CLK);
        e = exp_q.pop_front();
        n_chk++;
        if (obs !== e) begin n_err++; $display("FAIL flush_over_lu got=%b exp=%b", obs, e); end
        model_update(e, bus.ihit);
        @(posedge CLK); #1;
        n_chk++;
        if (bus.flush_count !== exp_flush) begin
            n_err++; $display("FAIL flush_over_lu_count got=%0d exp=%0d", bus.flush_count, exp_flush);
        end
    endtask

    task automatic test_mem_wait();
        logic [6:0] e;
        for (int c = 0; c < 6; c++) begin
            clear_inputs();
            bus.ihit = 1'b1;
            bus.em_mem_req = (c <= 4);
            bus.dhit = (c == 4);
            bus.ex_halt = (c == 2);
            exp_q.push_back((c >= 1 && c <= 4) ? O_MW : O_RUN);
            @(negedge CLK);
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL mem_wait_c%0d got=%b exp=%b", c, obs, e); end
            model_update(e, bus.ihit);
            @(posedge CLK); #1;
        end
        n_chk++;
        if (bus.stall_count !== exp_stall) begin
            n_err++; $display("FAIL mem_wait_stall_count got=%0d exp=%0d", bus.stall_count, exp_stall);
        end
    endtask

    task automatic test_saturation();
        logic [6:0] e;
        for (int c = 0; c < 12; c++) begin
            clear_inputs();
            bus.ihit = 1'b1; bus.de_Mem_Read = 1'b1; bus.de_wsel = 5'd9;
            bus.fd_uses_rs1 = 1'b1; bus.fd_rsel1 = 5'd9;
            exp_q.push_back(O_LU);
            @(negedge CLK);
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL saturate_c%0d got=%b exp=%b", c, obs, e); end
            model_update(e, bus.ihit);
            @(posedge CLK); #1;
        end
        n_chk++;
        if (bus.stall_count !== exp_stall || bus.stall_count !== 4'hF) begin
            n_err++; $display("FAIL stall_saturate got=%0d exp=%0d", bus.stall_count, exp_stall);
        end
    endtask

    task automatic test_halt_reset();
        logic [6:0] e;
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            bus.ex_halt = (c == 0);
            bus.ihit = (c == 0);
            bus.ex_redirect = (c == 3);
            exp_q.push_back(c == 0 ? O_RUN : O_HALT);
            @(negedge CLK);
            e = exp_q.pop_front();
            n_chk++;
            if (obs !== e) begin n_err++; $display("FAIL halt_c%0d got=%b exp=%b", c, obs, e); end
            model_update(e, bus.ihit);
            @(posedge CLK); #1;
        end
        // Asynchronous reset pulse in the middle of a cycle, with a flush pending.
        clear_inputs();
        bus.ihit = 1'b1;
        #2;
        nRST = 1'b0;
        exp_stall = '0;
        exp_flush = '0;
        exp_q.push_back(O_OFF);
        #1;
        e = exp_q.pop_front();
        n_chk++;
        if (obs !== e) begin n_err++; $display("FAIL async_reset_outputs got=%b exp=%b", obs, e); end
        n_chk++;
        if (bus.stall_count !== exp_stall || bus.flush_count !== exp_flush) begin
            n_err++;
            $display("FAIL async_reset_counters got=%0d/%0d exp=0/0", bus.stall_count, bus.flush_count);
        end
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;
        exp_q.push_back(O_RUN);
        @(negedge CLK);
        e = exp_q.pop_front();
        n_chk++;
        if (obs !== e) begin n_err++; $display("FAIL after_reset_run got=%b exp=%b", obs, e); end
        model_update(e, bus.ihit);
        @(posedge CLK); #1;
        n_chk++;
        if (bus.flush_count !== exp_flush || bus.stall_count !== exp_stall) begin
            n_err++;
            $display("FAIL after_reset_counters got=%0d/%0d exp=%0d/%0d",
                     bus.stall_count, bus.flush_count, exp_stall, exp_flush);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_hazard_cases();
        test_load_use();
        test_redirect_miss();
        test_flush_over_lu();
        test_mem_wait();
        test_saturation();
        test_halt_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
